// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback arbiter.
// Lane state enum plus default address and counter widths.
package wb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

  localparam int REG_AW_DEF  = 5;
  localparam int VREG_AW_DEF = 5;
  localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/wb_arb_lane.sv
// One writeback lane: decides live vs. parked vector result.
// Holds the one-deep park state and its destination.
module wb_arb_lane
  import wb_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_eff,
  input  logic          v_req,
  input  logic [AW-1:0] v_dst,
  output logic          sel,
  output logic          bsel,
  output logic          cap,
  output logic          valid,
  output logic [AW-1:0] dst
);

  lane_state_t state;
  lane_state_t state_nxt;

  // State and parked destination; reset discards any parked result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      dst   <= '0;
    end else begin
      state <= state_nxt;
      if (cap) dst <= v_dst;
    end
  end

  // Next state: park on conflict, refill while draining, else empty.
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: state_nxt = (v_req && s_eff) ? FULL : EMPTY;
      FULL:  state_nxt = v_req ? FULL : EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Select and capture controls; a full buffer always drains first.
  always_comb begin
    sel  = 1'b0;
    bsel = 1'b0;
    cap  = 1'b0;
    unique case (state)
      EMPTY: begin
        sel = v_req & ~s_eff;
        cap = v_req & s_eff;
      end
      FULL: begin
        sel  = 1'b1;
        bsel = 1'b1;
        cap  = v_req;
      end
      default: begin
        sel  = 1'b0;
        bsel = 1'b0;
        cap  = 1'b0;
      end
    endcase
  end

  assign valid = (state == FULL);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback port arbiter for scalar and vector register files.
// Vector results never stall; losers are parked one cycle.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int VREG_AW = VREG_AW_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_reg_req,
  input  logic               s_vec_req,
  input  logic               v_reg_req,
  input  logic               v_vec_req,
  input  logic [REG_AW-1:0]  v_reg_dst,
  input  logic [VREG_AW-1:0] v_vec_dst,
  output logic               register_wb_sel,
  output logic               buffer_register_sel,
  output logic               buffer_register,
  output logic               vector_wb_sel,
  output logic               buffer_vector_sel,
  output logic               buffer_vector,
  output logic               scalar_stall,
  output logic               reg_buf_valid,
  output logic [REG_AW-1:0]  reg_buf_dst,
  output logic               vec_buf_valid,
  output logic [VREG_AW-1:0] vec_buf_dst,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   park_cnt
);

  logic         s_reg_eff;
  logic         s_vec_eff;
  logic [CNT_W:0] park_sum;
  logic [CNT_W:0] stall_sum;

  // Stall uses only registered lane state, so lanes never loop.
  always_comb begin
    scalar_stall = (reg_buf_valid & s_reg_req)
                 | (vec_buf_valid & s_vec_req);
    s_reg_eff    = s_reg_req & ~scalar_stall;
    s_vec_eff    = s_vec_req & ~scalar_stall;
  end

  wb_arb_lane #(.AW(REG_AW)) u_reg (
    .clk   (clk),
    .rst   (rst),
    .s_eff (s_reg_eff),
    .v_req (v_reg_req),
    .v_dst (v_reg_dst),
    .sel   (register_wb_sel),
    .bsel  (buffer_register_sel),
    .cap   (buffer_register),
    .valid (reg_buf_valid),
    .dst   (reg_buf_dst)
  );

  wb_arb_lane #(.AW(VREG_AW)) u_vec (
    .clk   (clk),
    .rst   (rst),
    .s_eff (s_vec_eff),
    .v_req (v_vec_req),
    .v_dst (v_vec_dst),
    .sel   (vector_wb_sel),
    .bsel  (buffer_vector_sel),
    .cap   (buffer_vector),
    .valid (vec_buf_valid),
    .dst   (vec_buf_dst)
  );

  // Candidate counter values one bit wider to detect saturation.
  always_comb begin
    stall_sum = {1'b0, stall_cnt}
              + {{CNT_W{1'b0}}, scalar_stall};
    park_sum  = {1'b0, park_cnt}
              + {{CNT_W{1'b0}}, buffer_register}
              + {{CNT_W{1'b0}}, buffer_vector};
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      park_cnt  <= '0;
    end else begin
      stall_cnt <= stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
      park_cnt  <= park_sum[CNT_W]  ? '1 : park_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter.
// Each task drives one scenario and checks hand-computed values.
module tb_wb_arbiter;

  logic       clk;
  logic       rst;
  logic       s_reg_req;
  logic       s_vec_req;
  logic       v_reg_req;
  logic       v_vec_req;
  logic [4:0] v_reg_dst;
  logic [4:0] v_vec_dst;
  logic       register_wb_sel;
  logic       buffer_register_sel;
  logic       buffer_register;
  logic       vector_wb_sel;
  logic       buffer_vector_sel;
  logic       buffer_vector;
  logic       scalar_stall;
  logic       reg_buf_valid;
  logic [4:0] reg_buf_dst;
  logic       vec_buf_valid;
  logic [4:0] vec_buf_dst;
  logic [15:0] stall_cnt;
  logic [15:0] park_cnt;

  int n_cmp;
  int n_bad;

  wb_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_reg_req           (s_reg_req),
    .s_vec_req           (s_vec_req),
    .v_reg_req           (v_reg_req),
    .v_vec_req           (v_vec_req),
    .v_reg_dst           (v_reg_dst),
    .v_vec_dst           (v_vec_dst),
    .register_wb_sel     (register_wb_sel),
    .buffer_register_sel (buffer_register_sel),
    .buffer_register     (buffer_register),
    .vector_wb_sel       (vector_wb_sel),
    .buffer_vector_sel   (buffer_vector_sel),
    .buffer_vector       (buffer_vector),
    .scalar_stall        (scalar_stall),
    .reg_buf_valid       (reg_buf_valid),
    .reg_buf_dst         (reg_buf_dst),
    .vec_buf_valid       (vec_buf_valid),
    .vec_buf_dst         (vec_buf_dst),
    .stall_cnt           (stall_cnt),
    .park_cnt            (park_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {reg sel,bsel,cap, vec sel,bsel,cap, stall}
  function automatic logic [6:0] ctl();
    return {register_wb_sel, buffer_register_sel, buffer_register,
            vector_wb_sel, buffer_vector_sel, buffer_vector,
            scalar_stall};
  endfunction

  task automatic drive(input logic sr, input logic sv,
                       input logic vr, input logic vv,
                       input logic [4:0] rd, input logic [4:0] vd);
    s_reg_req = sr;
    s_vec_req = sv;
    v_reg_req = vr;
    v_vec_req = vv;
    v_reg_dst = rd;
    v_vec_dst = vd;
  endtask

  // Advance one clock, then settle inputs away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 5'd0, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (ctl() !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctl got %b want %b", ctl(), 7'b0);
    end
    n_cmp++;
    if ({reg_buf_valid, vec_buf_valid, reg_buf_dst, vec_buf_dst}
        !== 12'b0) begin
      n_bad++;
      $display("FAIL reset_buf got %b/%b want 0/0",
               reg_buf_valid, vec_buf_valid);
    end
    n_cmp++;
    if ({stall_cnt, park_cnt} !== 32'b0) begin
      n_bad++;
      $display("FAIL reset_cnt got %h/%h want 0/0", stall_cnt, park_cnt);
    end
  endtask

  task automatic test_park();
    do_reset();
    drive(1, 0, 1, 0, 5'd7, 5'd0);
    #1;
    n_cmp++;
    if (ctl() !== 7'b001_000_0) begin
      n_bad++;
      $display("FAIL park_cap got %b want %b", ctl(), 7'b0010000);
    end
    step();
    drive(1, 0, 0, 0, 5'd0, 5'd0);
    #1;
    n_cmp++;
    if (ctl() !== 7'b110_000_1) begin
      n_bad++;
      $display("FAIL park_drain got %b want %b", ctl(), 7'b1100001);
    end
    n_cmp++;
    if ({reg_buf_valid, reg_buf_dst} !== {1'b1, 5'd7}) begin
      n_bad++;
      $display("FAIL park_dst got %b/%0d want 1/7",
               reg_buf_valid, reg_buf_dst);
    end
    step();
    #1;
    n_cmp++;
    if ({ctl(), reg_buf_valid} !== 8'b0) begin
      n_bad++;
      $display("FAIL park_grant got %b want 0", {ctl(), reg_buf_valid});
    end
    n_cmp++;
    if ({stall_cnt, park_cnt} !== {16'd1, 16'd1}) begin
      n_bad++;
      $display("FAIL park_cnt got %0d/%0d want 1/1", stall_cnt, park_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 0, 1, 0, 5'd3, 5'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 5'd9, 5'd0);
      #1;
      n_cmp++;
      if (ctl() !== 7'b111_000_1) begin
        n_bad++;
        $display("FAIL b2b_ctl%0d got %b want %b", i, ctl(), 7'b1110001);
      end
      step();
    end
    drive(0, 0, 0, 0, 5'd0, 5'd0);
    #1;
    n_cmp++;
    if ({reg_buf_valid, reg_buf_dst} !== {1'b1, 5'd9}) begin
      n_bad++;
      $display("FAIL b2b_dst got %b/%0d want 1/9",
               reg_buf_valid, reg_buf_dst);
    end
    n_cmp++;
    if ({stall_cnt, park_cnt} !== {16'd3, 16'd4}) begin
      n_bad++;
      $display("FAIL b2b_cnt got %0d/%0d want 3/4", stall_cnt, park_cnt);
    end
  endtask

  task automatic test_cross_lane();
    do_reset();
    drive(1, 0, 1, 0, 5'd5, 5'd0);
    step();
    drive(1, 1, 0, 1, 5'd0, 5'd12);
    #1;
    n_cmp++;
    if (ctl() !== 7'b110_100_1) begin
      n_bad++;
      $display("FAIL cross_ctl got %b want %b", ctl(), 7'b1101001);
    end
    step();
    drive(0, 0, 0, 0, 5'd0, 5'd0);
    #1;
    n_cmp++;
    if ({reg_buf_valid, vec_buf_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL cross_buf got %b want 00",
               {reg_buf_valid, vec_buf_valid});
    end
  endtask

  task automatic test_dual_conflict();
    do_reset();
    drive(1, 1, 1, 1, 5'd2, 5'd4);
    #1;
    n_cmp++;
    if (ctl() !== 7'b001_001_0) begin
      n_bad++;
      $display("FAIL dual_cap got %b want %b", ctl(), 7'b0010010);
    end
    step();
    drive(0, 0, 0, 0, 5'd0, 5'd0);
    #1;
    n_cmp++;
    if (ctl() !== 7'b110_110_0) begin
      n_bad++;
      $display("FAIL dual_drain got %b want %b", ctl(), 7'b1101100);
    end
    n_cmp++;
    if ({reg_buf_dst, vec_buf_dst, park_cnt} !== {5'd2, 5'd4, 16'd2}) begin
      n_bad++;
      $display("FAIL dual_dst got %0d/%0d/%0d want 2/4/2",
               reg_buf_dst, vec_buf_dst, park_cnt);
    end
    step();
    #1;
    n_cmp++;
    if ({reg_buf_valid, vec_buf_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL dual_empty got %b want 00",
               {reg_buf_valid, vec_buf_valid});
    end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(1, 0, 1, 0, 5'd1, 5'd0);
    repeat (66000) step();
    #1;
    n_cmp++;
    if ({stall_cnt, park_cnt} !== {16'hFFFF, 16'hFFFF}) begin
      n_bad++;
      $display("FAIL sat_cnt got %h/%h want ffff/ffff",
               stall_cnt, park_cnt);
    end
    drive(0, 0, 0, 0, 5'd0, 5'd0);
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(0, 1, 0, 1, 5'd0, 5'd11);
    step();
    drive(0, 0, 0, 0, 5'd0, 5'd0);
    #1;
    n_cmp++;
    if ({vec_buf_valid, vec_buf_dst} !== {1'b1, 5'd11}) begin
      n_bad++;
      $display("FAIL ar_park got %b/%0d want 1/11",
               vec_buf_valid, vec_buf_dst);
    end
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({vec_buf_valid, vector_wb_sel} !== 2'b00) begin
      n_bad++;
      $display("FAIL ar_clear got %b want 00",
               {vec_buf_valid, vector_wb_sel});
    end
    #2;
    rst = 1'b1;
    step();
    #1;
    n_cmp++;
    if ({ctl(), vec_buf_valid, vec_buf_dst} !== 13'b0) begin
      n_bad++;
      $display("FAIL ar_nodrain got %b want 0",
               {ctl(), vec_buf_valid, vec_buf_dst});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    drive(0, 0, 0, 0, 5'd0, 5'd0);
    test_reset();
    test_park();
    test_back_to_back();
    test_cross_lane();
    test_dual_conflict();
    test_async_reset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
